// File: rtl/committed_store_buffer_if.sv
// Store-commit / memory-drain / load-forward bundle for committed_store_buffer.
// slave  : buffer side (takes commits, ready and load address; drives the rest).
// master : commit unit, memory and load pipe side.
interface committed_store_buffer_if #(
  parameter int unsigned COMMIT_WIDTH = 4,
  parameter int unsigned DEPTH        = 8
);
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic [COMMIT_WIDTH-1:0]       store_commit;
  logic [COMMIT_WIDTH-1:0][6:0]  store_commit_rob_idx;
  logic [COMMIT_WIDTH-1:0][31:0] store_commit_addr;
  logic [COMMIT_WIDTH-1:0][31:0] store_commit_data;
  logic [COMMIT_WIDTH-1:0][3:0]  store_commit_be;
  logic [CNT_W-1:0]              free_slots;
  logic                          csb_empty;
  logic                          mem_req_valid;
  logic [31:0]                   mem_req_addr;
  logic [31:0]                   mem_req_data;
  logic [3:0]                    mem_req_be;
  logic [6:0]                    mem_req_rob_idx;
  logic                          mem_req_ready;
  logic [31:0]                   ld_fwd_addr;
  logic [3:0]                    ld_fwd_be;
  logic [31:0]                   ld_fwd_data;
  logic                          overflow_err;
  logic [31:0]                   drained_stores;

  modport slave (
    input  store_commit, store_commit_rob_idx, store_commit_addr,
           store_commit_data, store_commit_be, mem_req_ready, ld_fwd_addr,
    output free_slots, csb_empty, mem_req_valid, mem_req_addr, mem_req_data,
           mem_req_be, mem_req_rob_idx, ld_fwd_be, ld_fwd_data, overflow_err,
           drained_stores
  );

  modport master (
    output store_commit, store_commit_rob_idx, store_commit_addr,
           store_commit_data, store_commit_be, mem_req_ready, ld_fwd_addr,
    input  free_slots, csb_empty, mem_req_valid, mem_req_addr, mem_req_data,
           mem_req_be, mem_req_rob_idx, ld_fwd_be, ld_fwd_data, overflow_err,
           drained_stores
  );
endinterface

// File: rtl/committed_store_buffer.sv
// Post-commit store buffer: queues up to COMMIT_WIDTH retired stores per cycle
// in program order, drains them one per handshake to memory, and forwards
// buffered bytes to younger loads.
// Ports: clk, rst_n (async active-low), bus (committed_store_buffer_if.slave):
//   commit lanes in, free_slots/csb_empty capacity out, mem_req_* drain
//   handshake, ld_fwd_* load forwarding, overflow_err sticky, drained_stores.
module committed_store_buffer #(
  parameter int unsigned COMMIT_WIDTH = 4,
  parameter int unsigned DEPTH        = 8,
  parameter int unsigned ROB_ENTRIES  = 64
) (
  input logic                      clk,
  input logic                      rst_n,
  committed_store_buffer_if.slave  bus
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned ROB_W = $clog2(ROB_ENTRIES) + 1;

  // Only the word address is kept: memory sees it word-aligned and
  // forwarding compares bits [31:2].
  typedef struct packed {
    logic [ROB_W-1:0] rob_idx;
    logic [29:0]      word;
    logic [31:0]      data;
    logic [3:0]       be;
  } entry_t;

  entry_t           entries_q [DEPTH];
  logic [PTR_W-1:0] head_q;
  logic [PTR_W-1:0] tail_q;
  logic [CNT_W-1:0] count_q;
  logic             overflow_q;
  logic [31:0]      drained_q;

  logic [CNT_W-1:0]        free_c;
  logic [CNT_W-1:0]        n_enq_c;
  logic [COMMIT_WIDTH-1:0] lane_we_c;
  logic [PTR_W-1:0]        lane_slot_c [COMMIT_WIDTH];
  logic                    drop_c;
  logic                    valid_c;
  logic                    deq_c;
  entry_t                  head_c;
  logic [PTR_W-1:0]        fwd_slot_c;
  logic [3:0]              fwd_be_c;
  logic [31:0]             fwd_data_c;
  logic                    unused_addr_lsbs;

  // Capacity comes from the pre-edge count, so a slot freed this cycle is not reused.
  assign free_c  = CNT_W'(DEPTH) - count_q;
  assign valid_c = (count_q != '0);
  assign deq_c   = valid_c && bus.mem_req_ready;
  assign head_c  = entries_q[head_q];

  // Compact valid lanes oldest-first onto tail slots; lanes beyond capacity drop.
  always_comb begin
    n_enq_c   = '0;
    drop_c    = 1'b0;
    lane_we_c = '0;
    for (int i = 0; i < COMMIT_WIDTH; i++) begin
      lane_slot_c[i] = '0;
    end
    for (int i = 0; i < COMMIT_WIDTH; i++) begin
      if (bus.store_commit[i]) begin
        if (n_enq_c < free_c) begin
          lane_we_c[i]   = 1'b1;
          lane_slot_c[i] = tail_q + n_enq_c[PTR_W-1:0];
          n_enq_c        = n_enq_c + CNT_W'(1);
        end else begin
          drop_c = 1'b1;
        end
      end
    end
  end

  // Payload storage; not reset since outputs are gated by occupancy.
  always_ff @(posedge clk) begin
    for (int i = 0; i < COMMIT_WIDTH; i++) begin
      if (lane_we_c[i]) begin
        entries_q[lane_slot_c[i]] <= '{
          rob_idx: ROB_W'(bus.store_commit_rob_idx[i]),
          word:    bus.store_commit_addr[i][31:2],
          data:    bus.store_commit_data[i],
          be:      bus.store_commit_be[i]
        };
      end
    end
  end

  // Pointers, occupancy and status.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      drained_q  <= '0;
    end else begin
      tail_q  <= tail_q + n_enq_c[PTR_W-1:0];
      count_q <= count_q + n_enq_c - CNT_W'(deq_c);
      if (deq_c) begin
        head_q    <= head_q + PTR_W'(1);
        drained_q <= drained_q + 32'd1;
      end
      if (drop_c) begin
        overflow_q <= 1'b1;
      end
    end
  end

  // Walk held entries oldest to youngest so younger matches overwrite older bytes.
  always_comb begin
    fwd_be_c   = '0;
    fwd_data_c = '0;
    fwd_slot_c = '0;
    for (int k = 0; k < DEPTH; k++) begin
      fwd_slot_c = head_q + PTR_W'(k);
      if ((CNT_W'(k) < count_q) &&
          (entries_q[fwd_slot_c].word == bus.ld_fwd_addr[31:2])) begin
        for (int b = 0; b < 4; b++) begin
          if (entries_q[fwd_slot_c].be[b]) begin
            fwd_be_c[b]          = 1'b1;
            fwd_data_c[8*b +: 8] = entries_q[fwd_slot_c].data[8*b +: 8];
          end
        end
      end
    end
  end

  // Byte-offset bits are irrelevant to a word-granular buffer.
  always_comb begin
    unused_addr_lsbs = ^bus.ld_fwd_addr[1:0];
    for (int i = 0; i < COMMIT_WIDTH; i++) begin
      unused_addr_lsbs = unused_addr_lsbs ^ (^bus.store_commit_addr[i][1:0]);
    end
  end

  assign bus.free_slots      = free_c;
  assign bus.csb_empty       = ~valid_c;
  assign bus.mem_req_valid   = valid_c;
  assign bus.mem_req_addr    = valid_c ? {head_c.word, 2'b00} : 32'd0;
  assign bus.mem_req_data    = valid_c ? head_c.data : 32'd0;
  assign bus.mem_req_be      = valid_c ? head_c.be : 4'd0;
  assign bus.mem_req_rob_idx = valid_c ? 7'(head_c.rob_idx) : 7'd0;
  assign bus.ld_fwd_be       = fwd_be_c;
  assign bus.ld_fwd_data     = fwd_data_c;
  assign bus.overflow_err    = overflow_q;
  assign bus.drained_stores  = drained_q;

endmodule

// File: tb/tb_committed_store_buffer.sv
// Self-checking bench for committed_store_buffer: directed scenarios followed
// by randomized commits/drains/loads, checked against a queue-based model.
module tb_committed_store_buffer;
  localparam int unsigned CW    = 4;
  localparam int unsigned DEPTH = 8;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
    logic [6:0]  rob;
  } ent_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  committed_store_buffer_if #(.COMMIT_WIDTH(CW), .DEPTH(DEPTH)) bus();

  committed_store_buffer #(
    .COMMIT_WIDTH(CW),
    .DEPTH       (DEPTH),
    .ROB_ENTRIES (64)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  ent_t        q[$];
  bit          m_ovf;
  int unsigned m_drained;
  int          n_pass;
  int          n_total;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
  endtask

  // Per byte, the youngest held store covering it supplies the data.
  task automatic model_fwd(output logic [3:0] be, output logic [31:0] data);
    be   = '0;
    data = '0;
    for (int b = 0; b < 4; b++) begin
      for (int j = q.size() - 1; j >= 0; j--) begin
        if (q[j].addr[31:2] == bus.ld_fwd_addr[31:2] && q[j].be[b]) begin
          be[b]          = 1'b1;
          data[8*b +: 8] = q[j].data[8*b +: 8];
          break;
        end
      end
    end
  endtask

  task automatic check_all(input string ph);
    logic [3:0]  fbe;
    logic [31:0] fd;
    logic [31:0] e_addr, e_data;
    logic [3:0]  e_be;
    logic [6:0]  e_rob;
    model_fwd(fbe, fd);
    e_addr = '0; e_data = '0; e_be = '0; e_rob = '0;
    if (q.size() != 0) begin
      e_addr = {q[0].addr[31:2], 2'b00};
      e_data = q[0].data;
      e_be   = q[0].be;
      e_rob  = q[0].rob;
    end
    check({ph, ".free"},    32'(bus.free_slots), 32'(DEPTH - q.size()));
    check({ph, ".empty"},   32'(bus.csb_empty), 32'(q.size() == 0));
    check({ph, ".valid"},   32'(bus.mem_req_valid), 32'(q.size() != 0));
    check({ph, ".addr"},    bus.mem_req_addr, e_addr);
    check({ph, ".data"},    bus.mem_req_data, e_data);
    check({ph, ".be"},      32'(bus.mem_req_be), 32'(e_be));
    check({ph, ".rob"},     32'(bus.mem_req_rob_idx), 32'(e_rob));
    check({ph, ".ovf"},     32'(bus.overflow_err), 32'(m_ovf));
    check({ph, ".drained"}, bus.drained_stores, m_drained);
    check({ph, ".fwd_be"},  32'(bus.ld_fwd_be), 32'(fbe));
    check({ph, ".fwd_data"}, bus.ld_fwd_data, fd);
  endtask

  // Advance the model across one clock edge using the inputs now on the bus.
  task automatic model_update();
    int   free;
    int   acc;
    ent_t e;
    free = int'(DEPTH) - q.size();
    acc  = 0;
    if (q.size() != 0 && bus.mem_req_ready) begin
      void'(q.pop_front());
      m_drained++;
    end
    for (int i = 0; i < CW; i++) begin
      if (bus.store_commit[i]) begin
        if (acc < free) begin
          e.addr = bus.store_commit_addr[i];
          e.data = bus.store_commit_data[i];
          e.be   = bus.store_commit_be[i];
          e.rob  = bus.store_commit_rob_idx[i];
          q.push_back(e);
          acc++;
        end else begin
          m_ovf = 1'b1;
        end
      end
    end
  endtask

  // Called at a falling edge with inputs set; returns at the next falling edge.
  task automatic step(input string ph);
    #1;
    check_all(ph);
    model_update();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clear_lanes();
    bus.store_commit         = '0;
    bus.store_commit_rob_idx = '0;
    bus.store_commit_addr    = '0;
    bus.store_commit_data    = '0;
    bus.store_commit_be      = '0;
  endtask

  task automatic set_lane(input int i, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] be);
    bus.store_commit[i]         = 1'b1;
    bus.store_commit_addr[i]    = a;
    bus.store_commit_data[i]    = d;
    bus.store_commit_be[i]      = be;
    bus.store_commit_rob_idx[i] = 7'($urandom);
  endtask

  task automatic model_reset();
    q.delete();
    m_ovf     = 1'b0;
    m_drained = 0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_lanes();
    bus.mem_req_ready = 1'b0;
    model_reset();
    #1;
    check_all("rst");
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    clear_lanes();
    bus.mem_req_ready = 1'b0;
    bus.ld_fwd_addr   = '0;
    model_reset();
    @(negedge clk);
    do_reset();

    // Gapped lanes 0 and 2, drained back to back.
    set_lane(0, 32'h100, 32'hAAAA_AAAA, 4'hF);
    set_lane(2, 32'h104, 32'hBBBB_BBBB, 4'hF);
    bus.mem_req_ready = 1'b1;
    step("t1c");
    clear_lanes();
    check("t1.head0", bus.mem_req_addr, 32'h100);
    step("t1d0");
    check("t1.head1", bus.mem_req_addr, 32'h104);
    step("t1d1");
    check("t1.drained", bus.drained_stores, 32'd2);
    check("t1.empty", 32'(bus.csb_empty), 32'd1);

    // Fill to full with memory stalled, then overflow.
    bus.mem_req_ready = 1'b0;
    check("t2.free8", 32'(bus.free_slots), 32'd8);
    for (int i = 0; i < 4; i++) set_lane(i, 32'h300 + 32'(4*i), $urandom, 4'hF);
    step("t2a");
    check("t2.free4", 32'(bus.free_slots), 32'd4);
    for (int i = 0; i < 4; i++) set_lane(i, 32'h310 + 32'(4*i), $urandom, 4'hF);
    step("t2b");
    check("t2.free0", 32'(bus.free_slots), 32'd0);
    clear_lanes();
    set_lane(0, 32'h400, 32'h1234_5678, 4'hF);
    step("t2c");
    clear_lanes();
    check("t2.ovf", 32'(bus.overflow_err), 32'd1);
    check("t2.head_stable", bus.mem_req_addr, 32'h300);
    step("t2d");

    // Tail wrap, then simultaneous drain and commit at 7 entries.
    do_reset();
    for (int i = 0; i < 4; i++) set_lane(i, 32'h500 + 32'(4*i), $urandom, 4'(i + 1));
    step("t3a");
    clear_lanes();
    bus.mem_req_ready = 1'b1;
    for (int k = 0; k < 4; k++) step("t3d");
    bus.mem_req_ready = 1'b0;
    for (int i = 0; i < 4; i++) set_lane(i, 32'h600 + 32'(4*i), $urandom, 4'hF);
    step("t3b");
    clear_lanes();
    for (int i = 0; i < 3; i++) set_lane(i, 32'h610 + 32'(4*i), $urandom, 4'hF);
    step("t3c");
    clear_lanes();
    check("t3.free7", 32'(bus.free_slots), 32'd1);
    bus.mem_req_ready = 1'b1;
    set_lane(1, 32'h700, 32'hCAFE_F00D, 4'hF);
    step("t3e");
    clear_lanes();
    check("t3.free_hold", 32'(bus.free_slots), 32'd1);
    check("t3.head", bus.mem_req_addr, 32'h604);
    for (int k = 0; k < 7; k++) step("t3f");
    check("t3.empty", 32'(bus.csb_empty), 32'd1);

    // Byte-merge forwarding from two overlapping stores.
    do_reset();
    bus.ld_fwd_addr = 32'h201;
    set_lane(0, 32'h200, 32'h0000_1122, 4'b0011);
    set_lane(1, 32'h202, 32'h0033_4400, 4'b0110);
    step("t4a");
    clear_lanes();
    check("t4.fwd_be", 32'(bus.ld_fwd_be), 32'h7);
    check("t4.fwd_data", bus.ld_fwd_data, 32'h0033_4422);

    // Asynchronous reset with five entries and a pending handshake.
    for (int i = 0; i < 3; i++) set_lane(i, 32'h800 + 32'(4*i), $urandom, 4'hF);
    step("t5a");
    clear_lanes();
    bus.mem_req_ready = 1'b1;
    #2;
    check("t5.free_pre", 32'(bus.free_slots), 32'd3);
    check("t5.valid_pre", 32'(bus.mem_req_valid), 32'd1);
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all("t5rst");
    @(negedge clk);
    rst_n = 1'b1;
    bus.mem_req_ready = 1'b0;

    // Randomized traffic over a small address pool to exercise forwarding.
    for (int c = 0; c < 600; c++) begin
      int unsigned rdy_pct;
      clear_lanes();
      rdy_pct = ((c / 50) % 2 == 0) ? 30 : 80;
      for (int i = 0; i < CW; i++) begin
        if ($urandom_range(0, 99) < 45)
          set_lane(i, 32'h1000 + 32'($urandom_range(0, 3) * 4) + 32'($urandom_range(0, 3)),
                   $urandom, 4'($urandom));
      end
      bus.mem_req_ready = ($urandom_range(0, 99) < rdy_pct);
      bus.ld_fwd_addr   = 32'h1000 + 32'($urandom_range(0, 4) * 4) + 32'($urandom_range(0, 3));
      step("rnd");
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/committed_store_buffer.md
# committed_store_buffer

Post-commit store buffer on the store-commit interface: accepts up to COMMIT_WIDTH retired stores per cycle (each tagged with its ROB index, address, data and byte enables) and queues them in program order. It drains them one at a time to data memory with a valid/ready handshake. It forwards buffered bytes to younger loads and reports free capacity so the commit unit never retires more stores than it can hold. Committed stores are architectural state and are never flushed.

## Interface
Parameters:
- COMMIT_WIDTH, 4, commit lanes per cycle; lane 0 is oldest.
- DEPTH, 8, buffer entries; power of two, at least COMMIT_WIDTH.
- ROB_ENTRIES, 64, carried for ROB-index width consistency; unused in logic.

Ports:
- clk  in  1  rising-edge clock; the only clock.
- rst_n  in  1  asynchronous, active-low reset.
- store_commit  in  COMMIT_WIDTH  per-lane committed-store strobe.
- store_commit_rob_idx  in  7 x COMMIT_WIDTH  ROB index per lane; stored for debug and trace only.
- store_commit_addr  in  32 x COMMIT_WIDTH  byte address per lane.
- store_commit_data  in  32 x COMMIT_WIDTH  word-aligned store data per lane.
- store_commit_be  in  4 x COMMIT_WIDTH  byte enables per lane.
- free_slots  out  $clog2(DEPTH)+1  DEPTH minus the registered occupancy.
- csb_empty  out  1  occupancy == 0; used for SYNC and fences.
- mem_req_valid  out  1  head entry is presented to memory.
- mem_req_addr  out  32  head address with bits [1:0] forced to 0.
- mem_req_data  out  32  head data.
- mem_req_be  out  4  head byte enables.
- mem_req_rob_idx  out  7  head ROB index.
- mem_req_ready  in  1  memory accepts the head in this cycle.
- ld_fwd_addr  in  32  load address; only bits [31:2] are compared.
- ld_fwd_be  out  4  bytes supplied by the buffer.
- ld_fwd_data  out  32  forwarded bytes; 0 in lanes not set in ld_fwd_be.
- overflow_err  out  1  sticky; set when a store is dropped.
- drained_stores  out  32  count of memory handshakes completed.

## Operation
- Storage is a circular FIFO with head_ptr and tail_ptr, each $clog2(DEPTH) bits and wrapping naturally, plus count of $clog2(DEPTH)+1 bits.
- Enqueue:
  - Lanes with store_commit set are compacted in ascending lane order and written at tail, tail+1, and so on.
  - Gaps between lanes are allowed; for example, valid lanes 0 and 2 go to tail and tail+1.
  - n_enq is the popcount of accepted lanes.
- Capacity rule:
  - At most free_slots lanes are accepted, taken oldest lane first.
  - Any further valid lanes are dropped, and overflow_err is set and held until reset.
- Dequeue:
  - mem_req_valid = (count != 0), driven from the head entry.
  - A handshake is mem_req_valid && mem_req_ready. It advances head_ptr by 1 and increments drained_stores, which wraps modulo 2^32.
- The head payload is stable while mem_req_valid is high and mem_req_ready is low.
- Simultaneous enqueue and dequeue: count_next = count + n_enq - deq. The slot freed by a dequeue cannot be reused by an enqueue in the same cycle, because free_slots uses the pre-edge count.
- Forwarding (combinational, over entries currently held):
  - An entry matches when entry.addr[31:2] == ld_fwd_addr[31:2].
  - For each byte b, the youngest matching entry with be[b] set supplies data byte b and sets ld_fwd_be[b].
  - Stores enqueuing in the current cycle are not visible to forwarding.
- The block has no flush input. Pipeline flushes never alter its contents.

## Timing
- Reset (asynchronous on rst_n low, released synchronously to clk):
  - Pointers and count are 0.
  - free_slots=DEPTH, csb_empty=1, mem_req_valid=0.
  - mem_req_addr, mem_req_data, mem_req_be and mem_req_rob_idx are 0.
  - ld_fwd_be=0, ld_fwd_data=0, overflow_err=0, drained_stores=0.
- Reset asserted mid-operation discards all entries immediately, including an outstanding head handshake.
- Latency:
  - A store enqueued at edge N into an empty buffer drives mem_req_valid from after edge N.
  - Its handshake can complete at edge N+1.
  - Throughput is one drain per cycle.
- free_slots and csb_empty update only at clock edges; they never depend combinationally on store_commit or mem_req_ready.
- Full (count == DEPTH):
  - free_slots = 0 and every valid commit lane is dropped with overflow_err set.
  - A drain in that cycle still occurs.
- Empty: mem_req_valid = 0, and mem_req_ready is ignored.

## Test plan
- Reset, then commit lanes {0,2} with addr 0x100/0x104 and data 0xAAAA_AAAA/0xBBBB_BBBB, mem_req_ready=1 -> memory sees 0x100 then 0x104 on the next two edges; drained_stores=2; csb_empty=1 afterward.
- Hold mem_req_ready=0, commit 4 stores, then 4 more, then 1 more -> free_slots goes 8, 4, 0; the ninth store is dropped; overflow_err=1; head payload remains stable.
- Fill to 7 entries across a tail wrap, then drain and commit 1 in the same cycle -> count stays 7 and FIFO order is preserved across the wrap.
- Buffer holds [0x200 be=0011 data=0x0000_1122] followed by younger [0x202 be=0110 data=0x0033_4400]; ld_fwd_addr=0x201 -> ld_fwd_be=0111, ld_fwd_data=0x0033_4422.
- Assert rst_n low asynchronously while 5 entries are queued and mem_req_valid=1 -> all outputs return to reset values before the next edge.
